// File: rtl/efpga_cfu_pkg.sv
// Shared types and constants for the eFPGA CFU bridge: FSM states, beat counts
// and the nibble selector used to serialise operands onto the OPA/OPB lanes.
package efpga_cfu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_RECV,
        ST_RESP
    } state_e;

    localparam int OP_BEATS   = 8;
    localparam int RES_BEATS  = 3;
    localparam int RES_LANE_W = 12;

    // Beat k carries bits [4k+3:4k]; LSB nibble goes out first.
    function automatic logic [3:0] nibble_at(input logic [31:0] word, input logic [2:0] beat);
        return word[{beat, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/efpga_cfu_bridge_if.sv
// CPU-side request/response handshake of the CFU bridge. The CPU is the
// master; the bridge takes the slave modport.
interface efpga_cfu_bridge_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;

    modport master (
        output req_valid, req_rs1, req_rs2, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/efpga_cfu_bridge.sv
// Streams two 32-bit operands into the eFPGA west CPU I/O tiles as nibbles and,
// LATENCY cycles after the last operand beat, collects a 32-bit result in three beats.
module efpga_cfu_bridge
    import efpga_cfu_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic                     UserCLK,
    input  logic                     resetn,
    efpga_cfu_bridge_if.slave        cpu,
    output logic [3:0]               opa_o,
    output logic [3:0]               opb_o,
    input  logic [3:0]               res0_i,
    input  logic [3:0]               res1_i,
    input  logic [3:0]               res2_i,
    output logic                     busy
);

    // WAIT lasts LATENCY-1 cycles; unused when LATENCY is 1.
    localparam logic [7:0] WAIT_LAST = 8'((LATENCY > 1) ? (LATENCY - 2) : 0);

    state_e                      r_state;
    state_e                      w_state_next;
    logic [2:0]                  r_beat_cnt;
    logic [7:0]                  r_wait_cnt;
    logic [31:0]                 r_op_a;
    logic [31:0]                 r_op_b;
    logic [3:0]                  r_opa;
    logic [3:0]                  r_opb;
    logic [2*RES_LANE_W-1:0]     r_acc;
    logic [31:0]                 r_rsp_data;
    logic [RES_LANE_W-1:0]       w_res_word;
    logic                        w_send_last;
    logic                        w_recv_last;

    assign w_res_word  = {res2_i, res1_i, res0_i};
    assign w_send_last = (r_beat_cnt == 3'(OP_BEATS - 1));
    assign w_recv_last = (r_beat_cnt == 3'(RES_BEATS - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    // NOTE: the next state is defaulted first so no path through the case can infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (cpu.req_valid) w_state_next = ST_SEND;
            ST_SEND: if (w_send_last)   w_state_next = (LATENCY == 1) ? ST_RECV : ST_WAIT;
            ST_WAIT: if (r_wait_cnt == WAIT_LAST) w_state_next = ST_RECV;
            ST_RECV: if (w_recv_last)   w_state_next = ST_RESP;
            ST_RESP: if (cpu.rsp_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: the operand and accumulator registers are reset along with the
    // outputs; they are small and a known value simplifies debug after reset.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            r_beat_cnt <= '0;
            r_wait_cnt <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_acc      <= '0;
            r_rsp_data <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (cpu.req_valid) begin
                        r_op_a     <= cpu.req_rs1;
                        r_op_b     <= cpu.req_rs2;
                        r_opa      <= nibble_at(cpu.req_rs1, 3'd0);
                        r_opb      <= nibble_at(cpu.req_rs2, 3'd0);
                        r_beat_cnt <= '0;
                    end
                end
                ST_SEND: begin
                    if (w_send_last) begin
                        r_opa      <= '0;
                        r_opb      <= '0;
                        r_beat_cnt <= '0;
                        r_wait_cnt <= '0;
                    end else begin
                        r_opa      <= nibble_at(r_op_a, r_beat_cnt + 3'd1);
                        r_opb      <= nibble_at(r_op_b, r_beat_cnt + 3'd1);
                        r_beat_cnt <= r_beat_cnt + 3'd1;
                    end
                end
                ST_WAIT: r_wait_cnt <= r_wait_cnt + 8'd1;
                ST_RECV: begin
                    // Last beat keeps only res1/res0; res2 would land in bits [35:32].
                    if (w_recv_last) begin
                        r_rsp_data <= {w_res_word[7:0], r_acc};
                        r_beat_cnt <= '0;
                    end else begin
                        r_acc      <= {w_res_word, r_acc[2*RES_LANE_W-1:RES_LANE_W]};
                        r_beat_cnt <= r_beat_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu.req_ready = (r_state == ST_IDLE);
    assign cpu.rsp_valid = (r_state == ST_RESP);
    assign cpu.rsp_data  = r_rsp_data;
    assign busy          = (r_state != ST_IDLE);
    assign opa_o         = r_opa;
    assign opb_o         = r_opb;

endmodule

// File: tb/tb_efpga_cfu_bridge.sv
// Directed bench for efpga_cfu_bridge: three builds (LATENCY 2, 1, 255) driven by
// a nibble-serial loopback fabric model that can be skewed early/late by one cycle.
module tb_efpga_cfu_bridge;

    logic                 user_clk = 1'b0;
    logic                 resetn;
    logic [2:0]           req_valid;
    logic [2:0]           rsp_ready;
    logic [2:0][31:0]     rs1;
    logic [2:0][31:0]     rs2;
    logic [2:0][3:0]      res0;
    logic [2:0][3:0]      res1;
    logic [2:0][3:0]      res2;
    wire  [2:0]           req_ready;
    wire  [2:0]           rsp_valid;
    wire  [2:0]           busy;
    wire  [2:0][31:0]     rsp_data;
    wire  [2:0][3:0]      opa;
    wire  [2:0][3:0]      opb;

    int n_checks;
    int n_errors;

    always #5 user_clk = ~user_clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        efpga_cfu_bridge_if cpu ();

        assign cpu.req_valid = req_valid[g];
        assign cpu.req_rs1   = rs1[g];
        assign cpu.req_rs2   = rs2[g];
        assign cpu.rsp_ready = rsp_ready[g];
        assign req_ready[g]  = cpu.req_ready;
        assign rsp_valid[g]  = cpu.rsp_valid;
        assign rsp_data[g]   = cpu.rsp_data;

        efpga_cfu_bridge #(.LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 255))) u_dut (
            .UserCLK (user_clk),
            .resetn  (resetn),
            .cpu     (cpu.slave),
            .opa_o   (opa[g]),
            .opb_o   (opb[g]),
            .res0_i  (res0[g]),
            .res1_i  (res1[g]),
            .res2_i  (res2[g]),
            .busy    (busy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ne(input string tag, input logic [31:0] obs, input logic [31:0] bad);
        n_checks++;
        assert (obs !== bad) else begin
            n_errors++;
            $error("FAIL %s: observed %0h must differ from %0h", tag, obs, bad);
        end
    endtask

    task automatic drive_res(input int idx, input logic [11:0] w);
        res0[idx] = w[3:0];
        res1[idx] = w[7:4];
        res2[idx] = w[11:8];
    endtask

    // Called at a negedge. Runs one full request; the fabric side either loops
    // back the captured operand sum or returns fixed words, shifted by 'late' cycles.
    task automatic do_req(input int idx, input int lat, input logic [31:0] a, input logic [31:0] b,
                          input bit loopback, input logic [11:0] w0, input logic [11:0] w1,
                          input logic [11:0] w2, input int late, input int hold, input bit keep_valid,
                          input logic [31:0] na, input logic [31:0] nb, input bit expect_ok,
                          input logic [31:0] exp, output int waited);
        logic [31:0] cap_a;
        logic [31:0] cap_b;
        logic [31:0] sum;
        logic [11:0] words [3];
        int          wi;

        req_valid[idx] = 1'b1;
        rs1[idx]       = a;
        rs2[idx]       = b;
        rsp_ready[idx] = (hold == 0);
        waited         = 0;
        while (!req_ready[idx] && waited < 1000) begin
            @(negedge user_clk);
            waited++;
        end
        check("req_ready_before_accept", 32'(req_ready[idx]), 32'd1);
        @(posedge user_clk);
        #1;
        if (keep_valid) begin
            rs1[idx] = na;
            rs2[idx] = nb;
        end else begin
            req_valid[idx] = 1'b0;
        end

        cap_a    = '0;
        cap_b    = '0;
        words[0] = w0;
        words[1] = w1;
        words[2] = w2;
        for (int cyc = 1; cyc <= 11 + lat; cyc++) begin
            @(negedge user_clk);
            if (cyc <= 8) begin
                cap_a[4*(cyc-1) +: 4] = opa[idx];
                cap_b[4*(cyc-1) +: 4] = opb[idx];
                check("opa_beat", 32'(opa[idx]), 32'(a[4*(cyc-1) +: 4]));
                check("opb_beat", 32'(opb[idx]), 32'(b[4*(cyc-1) +: 4]));
            end
            if (cyc == 1) check("busy_in_send", 32'(busy[idx]), 32'd1);
            if (cyc == 8 && loopback) begin
                sum      = cap_a + cap_b;
                words[0] = sum[11:0];
                words[1] = sum[23:12];
                words[2] = {4'h0, sum[31:24]};
            end
            wi = cyc - (8 + lat) - late;
            if (wi >= 0 && wi <= 2) drive_res(idx, words[wi]);
            else                    drive_res(idx, 12'h5A5);
            if (cyc == 9) check("opa_idle_after_send", 32'(opa[idx]), 32'd0);
            if (cyc == 10 + lat) check("rsp_valid_before_resp", 32'(rsp_valid[idx]), 32'd0);
            if (cyc == 11 + lat) begin
                check("rsp_valid_in_resp", 32'(rsp_valid[idx]), 32'd1);
                check("req_ready_low_in_resp", 32'(req_ready[idx]), 32'd0);
            end
        end
        drive_res(idx, 12'h000);

        if (expect_ok) check("rsp_data", rsp_data[idx], exp);
        else           check_ne("rsp_data_skewed_fabric", rsp_data[idx], exp);

        for (int h = 0; h < hold; h++) begin
            check("hold_rsp_valid", 32'(rsp_valid[idx]), 32'd1);
            check("hold_req_ready", 32'(req_ready[idx]), 32'd0);
            check("hold_rsp_data", rsp_data[idx], exp);
            @(negedge user_clk);
        end
        rsp_ready[idx] = 1'b1;
        @(posedge user_clk);
        @(negedge user_clk);
        check("req_ready_after_handshake", 32'(req_ready[idx]), 32'd1);
        check("rsp_valid_after_handshake", 32'(rsp_valid[idx]), 32'd0);
        if (expect_ok) check("rsp_data_held_in_idle", rsp_data[idx], exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        n_checks  = 0;
        n_errors  = 0;
        req_valid = '0;
        rsp_ready = '0;
        rs1       = '0;
        rs2       = '0;
        res0      = '0;
        res1      = '0;
        res2      = '0;
        resetn    = 1'b0;
        repeat (2) @(negedge user_clk);

        check("reset_req_ready", 32'(req_ready[0]), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("reset_rsp_data", rsp_data[0], 32'd0);
        check("reset_opa", 32'(opa[0]), 32'd0);
        check("reset_opb", 32'(opb[0]), 32'd0);
        check("reset_busy_all", 32'(busy), 32'd0);

        resetn = 1'b1;
        @(negedge user_clk);

        // Loopback sum with LATENCY=2; opa sequence 8,7,...,1.
        do_req(0, 2, 32'h1234_5678, 32'h1111_1111, 1'b1, 12'h0, 12'h0, 12'h0, 0, 0, 1'b0,
               32'h0, 32'h0, 1'b1, 32'h2345_6789, w);

        // Fixed words; the top nibble of beat 2 (F) must be dropped.
        do_req(0, 2, 32'hA5A5_0F0F, 32'h5A5A_F0F0, 1'b0, 12'hABC, 12'hDEF, 12'hF12, 0, 0, 1'b0,
               32'h0, 32'h0, 1'b1, 32'h12DE_FABC, w);

        // Backpressure with a second request already waiting.
        do_req(0, 2, 32'h0000_00FF, 32'h0000_0001, 1'b1, 12'h0, 12'h0, 12'h0, 0, 5, 1'b1,
               32'h2000_0003, 32'h0000_0004, 1'b1, 32'h0000_0100, w);
        do_req(0, 2, 32'h2000_0003, 32'h0000_0004, 1'b1, 12'h0, 12'h0, 12'h0, 0, 0, 1'b0,
               32'h0, 32'h0, 1'b1, 32'h2000_0007, w);
        check("stalled_req_accepted_next_cycle", 32'(w), 32'd0);

        // Reset during SEND beat 4.
        req_valid[0] = 1'b1;
        rs1[0]       = 32'hCAFE_F00D;
        rs2[0]       = 32'h1357_9BDF;
        rsp_ready[0] = 1'b1;
        @(posedge user_clk);
        #1;
        req_valid[0] = 1'b0;
        repeat (5) @(negedge user_clk);
        check("beat4_opa", 32'(opa[0]), 32'hE);
        check("beat4_opb", 32'(opb[0]), 32'h7);
        resetn = 1'b0;
        #1;
        check("midreset_opa", 32'(opa[0]), 32'd0);
        check("midreset_opb", 32'(opb[0]), 32'd0);
        check("midreset_busy", 32'(busy[0]), 32'd0);
        check("midreset_req_ready", 32'(req_ready[0]), 32'd1);
        check("midreset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("midreset_rsp_data", rsp_data[0], 32'd0);
        @(negedge user_clk);
        resetn = 1'b1;
        @(negedge user_clk);
        do_req(0, 2, 32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 12'h0, 12'h0, 12'h0, 0, 0, 1'b0,
               32'h0, 32'h0, 1'b1, 32'h1010_1010, w);

        // LATENCY=1: aligned fabric, then one cycle late and one cycle early.
        do_req(1, 1, 32'h89AB_CDEF, 32'h1111_1111, 1'b1, 12'h0, 12'h0, 12'h0, 0, 0, 1'b0,
               32'h0, 32'h0, 1'b1, 32'h9ABC_DF00, w);
        do_req(1, 1, 32'h89AB_CDEF, 32'h1111_1111, 1'b1, 12'h0, 12'h0, 12'h0, 1, 0, 1'b0,
               32'h0, 32'h0, 1'b0, 32'h9ABC_DF00, w);
        do_req(1, 1, 32'h89AB_CDEF, 32'h1111_1111, 1'b1, 12'h0, 12'h0, 12'h0, -1, 0, 1'b0,
               32'h0, 32'h0, 1'b0, 32'h9ABC_DF00, w);

        // LATENCY=255: aligned fabric, then skewed either way.
        do_req(2, 255, 32'h7654_3210, 32'h0123_4567, 1'b1, 12'h0, 12'h0, 12'h0, 0, 0, 1'b0,
               32'h0, 32'h0, 1'b1, 32'h7777_7777, w);
        do_req(2, 255, 32'h7654_3210, 32'h0123_4567, 1'b1, 12'h0, 12'h0, 12'h0, 1, 0, 1'b0,
               32'h0, 32'h0, 1'b0, 32'h7777_7777, w);
        do_req(2, 255, 32'h7654_3210, 32'h0123_4567, 1'b1, 12'h0, 12'h0, 12'h0, -1, 0, 1'b0,
               32'h0, 32'h0, 1'b0, 32'h7777_7777, w);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/efpga_cfu_bridge.md
# efpga_cfu_bridge

CPU-side custom-function-unit bridge that drives the eFPGA's west CPU I/O tile column. It accepts a two-operand request from the CPU and streams both 32-bit operands into the fabric as nibbles on the OPA/OPB lanes. After a fixed fabric latency it collects a 32-bit result from the three 4-bit RES lanes and returns it to the CPU with a valid/ready handshake. Only one request is in flight at a time.

## Interface
- LATENCY, 2, cycles from the last operand beat to the first result beat on the RES lanes; legal range 1..255.
- UserCLK  in  1  fabric user clock; the bridge and the fabric share this clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  bridge can accept a request.
- req_rs1  in  32  operand A.
- req_rs2  in  32  operand B.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  CPU accepts result.
- rsp_data  out  32  result.
- opa_o  out  4  nibble lane to tile OPA_I3..0.
- opb_o  out  4  nibble lane to tile OPB_I3..0.
- res0_i, res1_i, res2_i  in  4 each  lanes from tile RES0_O3..0, RES1_O3..0 and RES2_O3..0.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states are IDLE, SEND, WAIT, RECV and RESP.
  - IDLE: req_ready=1. On req_valid the bridge latches rs1/rs2 into two 32-bit shift registers and moves to SEND. beat_cnt resets to 0.
  - SEND: 8 beats. Beat k drives opa_o=rs1[4k+3:4k] and opb_o=rs2[4k+3:4k], LSB nibble first. After beat 7 the FSM moves to WAIT; if LATENCY=1 it moves directly to RECV.
  - WAIT: LATENCY-1 cycles, then RECV.
  - RECV: 3 beats. Beat j samples the 12-bit word {res2_i,res1_i,res0_i} into acc[12j+11:12j]. acc is 36 bits wide and acc[35:32] is discarded, so only res1/res0 matter on beat 2. After beat 2 the FSM moves to RESP.
  - RESP: rsp_valid=1 and rsp_data=acc[31:0], held stable until rsp_ready. On the handshake the FSM returns to IDLE.
- opa_o and opb_o are registered outputs and are 4'h0 in every state except SEND.
- req_ready is low outside IDLE. A request arriving while busy is stalled, not dropped.
- rsp_data holds its last value outside RESP and is not cleared.
- RES lanes are sampled only in RECV. Values on them in any other state are ignored.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, opa_o=opb_o=0, busy=0, all counters 0.
- Reset asserted mid-operation: the in-flight request is lost and outputs take their reset values asynchronously. The fabric pipeline is not flushed.

## Timing
- Acceptance edge E: the edge at which req_valid && req_ready.
- Operand beat k is on opa_o/opb_o during cycle E+1+k, for k=0..7.
- Result beat j is sampled at the edge ending cycle E+8+LATENCY+j, for j=0..2.
- rsp_valid rises in cycle E+11+LATENCY.
- If rsp_ready is already high at that point, req_ready returns in the next cycle.
- Minimum request-to-request period is LATENCY+12 cycles.
- The fabric design must present result beat 0 exactly LATENCY cycles after it sees operand beat 7. There is no fabric-side valid strobe.

## Structure
- The package efpga_cfu_pkg holds:
  - the state enum;
  - OP_BEATS=8, RES_BEATS=3, RES_LANE_W=12;
  - the function that extracts a nibble by beat index.
- The block is a single module with no sub-modules: the FSM, a 3-bit beat counter, an 8-bit wait counter and the shift/accumulate registers.

## Test plan
- Reset while idle: check all outputs equal their reset values and req_ready=1.
- Loopback fabric model (LATENCY=2) returns rs1+rs2 nibble-serially as 12-bit words. Request rs1=32'h1234_5678, rs2=32'h1111_1111 → rsp_data=32'h2345_6789 with rsp_valid in cycle E+13. Check opa_o sequence 8,7,6,5,4,3,2,1.
- Drive RES words 12'hABC, 12'hDEF and 12'hF12 on the three beats → rsp_data=32'h12DE_FABC. Confirm the upper nibble of beat 2 is dropped.
- Hold rsp_ready low for 5 cycles with req_valid high → rsp_data stable and req_ready=0 throughout. After the handshake, the second request is accepted in the next cycle.
- Assert resetn low during SEND beat 4 → opa_o=0 immediately. After release, a fresh request completes correctly.
- LATENCY=1 and LATENCY=255 builds: verify result sampling lands exactly on the E+8+LATENCY+j edges and that an off-by-one fabric model produces a mismatch.
